fp_add_pipe: RTL and testbench

Parametrised, pipelined IEEE-754-style floating-point adder/subtractor with valid/ready handshakes on input and output. It extends the single-precision combinational adder to any exponent and mantissa width, adds a subtract mode and round-to-nearest-even, and raises exception flags. It accepts one operation per cycle and sits between operand-issue logic and any result consumer that may apply backpressure.

---
 rtl/fp_add_pipe.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_fp_add_pipe.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_pipe.sv
// fp_add_pipe: three-stage pipelined floating-point adder/subtractor with
// valid/ready handshakes, round-to-nearest-even and exception flags.
// Subnormal operands are read as zero and subnormal results flush to +0.
module fp_add_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  localparam int unsigned W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         flag_ovf,
  output logic         flag_inv,
  output logic         flag_zero
);

  localparam int unsigned SIG_W = MAN_W + 1;   // hidden bit + fraction
  localparam int unsigned EXT_W = MAN_W + 4;   // significand + guard, round, sticky
  localparam int unsigned SUM_W = MAN_W + 5;   // carry + extended significand
  localparam int unsigned MR_W  = MAN_W + 2;   // rounded significand + rounding carry
  localparam int unsigned LZ_W  = $clog2(EXT_W + 1);
  localparam int unsigned EW    = ((EXP_W > LZ_W) ? EXP_W : LZ_W) + 2;

  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic signed [EW-1:0] E_ONE = EW'(1);
  localparam logic signed [EW-1:0] E_MAX = EW'((1 << EXP_W) - 1);

  // Global stall: every stage moves only when the output slot can drain.
  logic advance;
  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;

  // ---------------------------------------------------------------------------
  // Unpack (B sign already folded with the subtract request)
  // ---------------------------------------------------------------------------
  logic             sign_a, sign_b;
  logic [EXP_W-1:0] exp_a, exp_b;
  logic [MAN_W-1:0] frac_a, frac_b;
  logic             zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;

  assign sign_a = a[W-1];
  assign sign_b = b[W-1] ^ sub;
  assign exp_a  = a[W-2:MAN_W];
  assign exp_b  = b[W-2:MAN_W];
  assign frac_a = a[MAN_W-1:0];
  assign frac_b = b[MAN_W-1:0];
  assign zero_a = (exp_a == '0);
  assign zero_b = (exp_b == '0);
  assign inf_a  = (exp_a == '1) && (frac_a == '0);
  assign inf_b  = (exp_b == '1) && (frac_b == '0);
  assign nan_a  = (exp_a == '1) && (frac_a != '0);
  assign nan_b  = (exp_b == '1) && (frac_b != '0);

  // ---------------------------------------------------------------------------
  // S1: specials, magnitude swap, alignment
  // ---------------------------------------------------------------------------
  logic [W-2:0]     mag_a, mag_b;
  logic [SIG_W-1:0] sig_a, sig_b, small_sig;
  logic [EXP_W-1:0] small_exp, diff;
  logic [EXT_W-1:0] small_ext, shifted, lost_mask;
  logic             swap;

  logic             al_special, al_inv, al_sign, al_eff_sub;
  logic [W-1:0]     al_spec_res;
  logic [EXP_W-1:0] al_exp;
  logic [SIG_W-1:0] al_sig_big;
  logic [EXT_W-1:0] al_sig_small;

  // Order operands by magnitude and shift the smaller one into GRS position.
  always_comb begin
    al_special  = 1'b0;
    al_inv      = 1'b0;
    al_spec_res = '0;

    mag_a = zero_a ? '0 : a[W-2:0];
    mag_b = zero_b ? '0 : b[W-2:0];
    sig_a = zero_a ? '0 : {1'b1, frac_a};
    sig_b = zero_b ? '0 : {1'b1, frac_b};
    swap  = (mag_b > mag_a);

    al_sign    = swap ? sign_b : sign_a;
    al_eff_sub = sign_a ^ sign_b;
    al_exp     = swap ? exp_b : exp_a;
    al_sig_big = swap ? sig_b : sig_a;
    small_sig  = swap ? sig_a : sig_b;
    small_exp  = swap ? exp_a : exp_b;

    diff      = al_exp - small_exp;
    small_ext = {small_sig, 3'b000};
    shifted   = small_ext >> diff;
    lost_mask = ~({EXT_W{1'b1}} << diff);

    if (32'(diff) >= 32'(MAN_W + 3)) begin
      al_sig_small = {{(EXT_W-1){1'b0}}, |small_sig};
    end else begin
      al_sig_small = {shifted[EXT_W-1:1], shifted[0] | (|(small_ext & lost_mask))};
    end

    if (nan_a || nan_b || (inf_a && inf_b && (sign_a != sign_b))) begin
      al_special  = 1'b1;
      al_inv      = 1'b1;
      al_spec_res = QNAN;
    end else if (inf_a) begin
      al_special  = 1'b1;
      al_spec_res = {sign_a, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (inf_b) begin
      al_special  = 1'b1;
      al_spec_res = {sign_b, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end
  end

  logic             s1_valid, s1_special, s1_inv, s1_sign, s1_eff_sub;
  logic [W-1:0]     s1_spec_res;
  logic [EXP_W-1:0] s1_exp;
  logic [SIG_W-1:0] s1_sig_big;
  logic [EXT_W-1:0] s1_sig_small;

  // S1 register: captures operands only on an accepted handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid     <= 1'b0;
      s1_special   <= 1'b0;
      s1_inv       <= 1'b0;
      s1_sign      <= 1'b0;
      s1_eff_sub   <= 1'b0;
      s1_spec_res  <= '0;
      s1_exp       <= '0;
      s1_sig_big   <= '0;
      s1_sig_small <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_special   <= al_special;
        s1_inv       <= al_inv;
        s1_sign      <= al_sign;
        s1_eff_sub   <= al_eff_sub;
        s1_spec_res  <= al_spec_res;
        s1_exp       <= al_exp;
        s1_sig_big   <= al_sig_big;
        s1_sig_small <= al_sig_small;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S2: significand add / subtract (|big| >= |small| so never negative)
  // ---------------------------------------------------------------------------
  logic [SUM_W-1:0] sum_n;

  // Effective add or subtract on the extended significands.
  always_comb begin
    sum_n = '0;
    if (s1_eff_sub) sum_n = {1'b0, s1_sig_big, 3'b000} - {1'b0, s1_sig_small};
    else            sum_n = {1'b0, s1_sig_big, 3'b000} + {1'b0, s1_sig_small};
  end

  logic             s2_valid, s2_special, s2_inv, s2_sign, s2_eff_sub;
  logic [W-1:0]     s2_spec_res;
  logic [EXP_W-1:0] s2_exp;
  logic [SUM_W-1:0] s2_sum;

  // S2 register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid    <= 1'b0;
      s2_special  <= 1'b0;
      s2_inv      <= 1'b0;
      s2_sign     <= 1'b0;
      s2_eff_sub  <= 1'b0;
      s2_spec_res <= '0;
      s2_exp      <= '0;
      s2_sum      <= '0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_special  <= s1_special;
        s2_inv      <= s1_inv;
        s2_sign     <= s1_sign;
        s2_eff_sub  <= s1_eff_sub;
        s2_spec_res <= s1_spec_res;
        s2_exp      <= s1_exp;
        s2_sum      <= sum_n;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S3: normalise, round to nearest even, classify
  // ---------------------------------------------------------------------------
  logic [LZ_W-1:0]     lz;
  logic                found, carry, round_up;
  logic [EXT_W-1:0]    norm;
  logic [MR_W-1:0]     mant_r;
  logic [MAN_W-1:0]    frac_fin;
  logic signed [EW-1:0] e_norm, e_fin;
  logic [W-1:0]        res_n;
  logic                ovf_n, inv_n, zero_n;

  // Leading-zero normalisation, RNE rounding and result selection.
  always_comb begin
    lz       = '0;
    found    = 1'b0;
    carry    = s2_sum[SUM_W-1];
    norm     = '0;
    e_norm   = '0;
    e_fin    = '0;
    mant_r   = '0;
    frac_fin = '0;
    round_up = 1'b0;
    res_n    = '0;
    ovf_n    = 1'b0;
    inv_n    = 1'b0;
    zero_n   = 1'b0;

    for (int i = int'(EXT_W) - 1; i >= 0; i--) begin
      if (!found) begin
        if (s2_sum[i]) found = 1'b1;
        else           lz = lz + LZ_W'(1);
      end
    end

    if (carry) begin
      norm   = {s2_sum[SUM_W-1:2], s2_sum[1] | s2_sum[0]};
      e_norm = EW'(s2_exp) + EW'(1);
    end else begin
      norm   = s2_sum[EXT_W-1:0] << lz;
      e_norm = EW'(s2_exp) - EW'(lz);
    end

    // guard & (round | sticky | lsb): ties go to the even neighbour
    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant_r   = {1'b0, norm[EXT_W-1:3]} + MR_W'(round_up);

    if (mant_r[MR_W-1]) begin
      frac_fin = mant_r[MAN_W:1];
      e_fin    = e_norm + EW'(1);
    end else begin
      frac_fin = mant_r[MAN_W-1:0];
      e_fin    = e_norm;
    end

    if (s2_special) begin
      res_n = s2_spec_res;
      inv_n = s2_inv;
    end else if (s2_sum == '0) begin
      // exact cancellation is +0; only (-0)+(-0) keeps the sign
      res_n  = {s2_sign & ~s2_eff_sub, {(W-1){1'b0}}};
      zero_n = 1'b1;
    end else if (e_fin < E_ONE) begin
      res_n  = '0;
      zero_n = 1'b1;
    end else if (e_fin >= E_MAX) begin
      res_n = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ovf_n = 1'b1;
    end else begin
      res_n = {s2_sign, e_fin[EXP_W-1:0], frac_fin};
    end
  end

  // Output register: holds result and flags stable while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      flag_ovf  <= 1'b0;
      flag_inv  <= 1'b0;
      flag_zero <= 1'b0;
    end else if (advance) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        result    <= res_n;
        flag_ovf  <= ovf_n;
        flag_inv  <= inv_n;
        flag_zero <= zero_n;
      end
    end
  end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Scoreboard bench for fp_add_pipe: single-precision and half-precision
// instances driven with hand-computed directed vectors.
module tb_fp_add_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // single precision instance
  logic        sp_in_valid, sp_in_ready, sp_sub, sp_out_valid, sp_out_ready;
  logic [31:0] sp_a, sp_b, sp_result;
  logic        sp_ovf, sp_inv, sp_zero;

  // half precision instance
  logic        hp_in_valid, hp_in_ready, hp_sub, hp_out_valid, hp_out_ready;
  logic [15:0] hp_a, hp_b, hp_result;
  logic        hp_ovf, hp_inv, hp_zero;

  fp_add_pipe u_sp (
    .clk(clk), .rst(rst), .in_valid(sp_in_valid), .in_ready(sp_in_ready),
    .a(sp_a), .b(sp_b), .sub(sp_sub), .out_valid(sp_out_valid),
    .out_ready(sp_out_ready), .result(sp_result), .flag_ovf(sp_ovf),
    .flag_inv(sp_inv), .flag_zero(sp_zero)
  );

  fp_add_pipe #(.EXP_W(5), .MAN_W(10)) u_hp (
    .clk(clk), .rst(rst), .in_valid(hp_in_valid), .in_ready(hp_in_ready),
    .a(hp_a), .b(hp_b), .sub(hp_sub), .out_valid(hp_out_valid),
    .out_ready(hp_out_ready), .result(hp_result), .flag_ovf(hp_ovf),
    .flag_inv(hp_inv), .flag_zero(hp_zero)
  );

  // expected flags are {ovf, inv, zero}
  typedef struct packed {
    logic [31:0] res;
    logic [2:0]  flg;
  } exp_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] r;
    logic [2:0]  f;
  } vec_t;

  localparam int NV = 18;
  localparam vec_t SP_VECS [NV] = '{
    '{32'h40600000, 32'h40600000, 1'b1, 32'h00000000, 3'b001},  // x - x
    '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b001},  // -0 + -0
    '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b000},  // tie, even
    '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b000},  // tie, odd
    '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b010},  // inf - inf
    '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b100},  // overflow
    '{32'h7F800000, 32'hFE000000, 1'b0, 32'h7F800000, 3'b000},  // inf + finite
    '{32'h3F800000, 32'h3F000000, 1'b1, 32'h3F000000, 3'b000},  // 1 - 0.5
    '{32'h40000000, 32'h40400000, 1'b1, 32'hBF800000, 3'b000},  // 2 - 3
    '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b010},  // NaN in
    '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 3'b001},  // underflow
    '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000},  // subnormal in
    '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000},  // carry out
    '{32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 3'b000},  // round carry
    '{32'hBF800000, 32'h3F000000, 1'b0, 32'hBF000000, 3'b000},  // -1 + 0.5
    '{32'h80000000, 32'h00000000, 1'b0, 32'h00000000, 3'b001},  // -0 + +0
    '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b010},  // inf - inf (sub)
    '{32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 3'b000}   // above half
  };

  exp_t sp_q[$];
  exp_t hp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  // Present one operation and hold it until the DUT accepts it.
  task automatic issue(input bit hp, input logic [31:0] ta, input logic [31:0] tbv,
                       input logic ts, input logic [31:0] er, input logic [2:0] ef);
    bit   ok;
    int   n;
    exp_t e;
    e.res = er;
    e.flg = ef;
    if (hp) begin
      hp_a = ta[15:0]; hp_b = tbv[15:0]; hp_sub = ts; hp_in_valid = 1'b1;
    end else begin
      sp_a = ta; sp_b = tbv; sp_sub = ts; sp_in_valid = 1'b1;
    end
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 40) begin
      @(negedge clk);
      ok = hp ? hp_in_ready : sp_in_ready;
      @(posedge clk);
      n++;
    end
    if (ok) begin
      if (hp) hp_q.push_back(e);
      else    sp_q.push_back(e);
    end else begin
      tests++;
      fails++;
      $display("FAIL issue_timeout hp=%0d in_ready stayed low for %0d cycles", hp, n);
    end
    #1;
    sp_in_valid = 1'b0;
    hp_in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 60 && (sp_q.size() != 0 || hp_q.size() != 0); n++) @(posedge clk);
    check("drain_sp_queue", 32'(sp_q.size()), 32'd0);
    check("drain_hp_queue", 32'(hp_q.size()), 32'd0);
  endtask

  // Single-precision monitor: compare head of queue whenever a result is shown.
  always @(negedge clk) begin
    if (!rst && sp_out_valid) begin
      tests++;
      if (sp_q.size() == 0) begin
        fails++;
        $display("FAIL sp_unexpected result=%h", sp_result);
      end else begin
        if (sp_result !== sp_q[0].res || {sp_ovf, sp_inv, sp_zero} !== sp_q[0].flg) begin
          fails++;
          $display("FAIL sp_result got=%h flags=%b want=%h flags=%b",
                   sp_result, {sp_ovf, sp_inv, sp_zero}, sp_q[0].res, sp_q[0].flg);
        end
        if (sp_out_ready) sp_q.delete(0);
      end
    end
  end

  // Half-precision monitor.
  always @(negedge clk) begin
    if (!rst && hp_out_valid) begin
      tests++;
      if (hp_q.size() == 0) begin
        fails++;
        $display("FAIL hp_unexpected result=%h", hp_result);
      end else begin
        if (hp_result !== hp_q[0].res[15:0] || {hp_ovf, hp_inv, hp_zero} !== hp_q[0].flg) begin
          fails++;
          $display("FAIL hp_result got=%h flags=%b want=%h flags=%b",
                   hp_result, {hp_ovf, hp_inv, hp_zero}, hp_q[0].res[15:0], hp_q[0].flg);
        end
        if (hp_out_ready) hp_q.delete(0);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  k;
    int  late;
    bit  rdy;
    exp_t e;

    rst = 1'b1;
    sp_in_valid = 1'b0; sp_a = '0; sp_b = '0; sp_sub = 1'b0; sp_out_ready = 1'b1;
    hp_in_valid = 1'b0; hp_a = '0; hp_b = '0; hp_sub = 1'b0; hp_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_out_valid", 32'(sp_out_valid), 32'd0);
    check("rst_result", sp_result, 32'd0);
    check("rst_flags", 32'({sp_ovf, sp_inv, sp_zero}), 32'd0);
    check("rst_in_ready", 32'(sp_in_ready), 32'd1);
    check("rst_hp_out_valid", 32'(hp_out_valid), 32'd0);
    @(posedge clk); #1;

    // latency: result visible at the third negedge after the accepting edge
    issue(1'b0, 32'h40780000, 32'h40600000, 1'b0, 32'h40EC0000, 3'b000);
    @(negedge clk);
    @(negedge clk); check("latency_early", 32'(sp_out_valid), 32'd0);
    @(negedge clk); check("latency_on_time", 32'(sp_out_valid), 32'd1);
    wait_drain();
    @(posedge clk); #1;

    // directed vectors, issued back to back
    for (int i = 0; i < NV; i++)
      issue(1'b0, SP_VECS[i].a, SP_VECS[i].b, SP_VECS[i].s, SP_VECS[i].r, SP_VECS[i].f);
    wait_drain();
    @(posedge clk); #1;

    // backpressure: 6 ops with out_ready low for the first 5 cycles
    sp_out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 40 && k < 6; c++) begin
      if (c == 5) sp_out_ready = 1'b1;
      sp_a = SP_VECS[k].a; sp_b = SP_VECS[k].b; sp_sub = SP_VECS[k].s;
      sp_in_valid = 1'b1;
      @(negedge clk);
      if (c < 5) check($sformatf("bp_in_ready_c%0d", c), 32'(sp_in_ready), (c < 3) ? 32'd1 : 32'd0);
      rdy = sp_in_ready;
      @(posedge clk);
      if (rdy) begin
        e.res = SP_VECS[k].r;
        e.flg = SP_VECS[k].f;
        sp_q.push_back(e);
        k++;
      end
      #1;
    end
    sp_in_valid = 1'b0;
    check("bp_all_issued", 32'(k), 32'd6);
    wait_drain();
    @(posedge clk); #1;

    // reset with two half-precision operations in flight
    issue(1'b1, 32'h3C00, 32'h3C00, 1'b0, 32'h4000, 3'b000);
    issue(1'b1, 32'h3C00, 32'h3800, 1'b0, 32'h3E00, 3'b000);
    rst = 1'b1;
    hp_q.delete();
    @(negedge clk);
    check("midrst_out_valid", 32'(hp_out_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    late = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (hp_out_valid) late++;
    end
    check("midrst_no_late_results", 32'(late), 32'd0);
    check("midrst_in_ready", 32'(hp_in_ready), 32'd1);
    @(posedge clk); #1;

    // half-precision directed vectors
    issue(1'b1, 32'h3C00, 32'h3C00, 1'b0, 32'h4000, 3'b000);
    issue(1'b1, 32'h7BFF, 32'h7BFF, 1'b0, 32'h7C00, 3'b100);
    issue(1'b1, 32'h7C00, 32'h7C00, 1'b1, 32'h7E00, 3'b010);
    issue(1'b1, 32'h3C00, 32'h3800, 1'b1, 32'h3800, 3'b000);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
